periph_bus_arbiter: RTL and testbench

- Shares the single peripheral bus (paddr/pwrite/psize/pread_req/pwrite_req/pread) between two masters: m0 is the CPU data port and m1 is a debug/DMA master.
- Each master raises a request and holds it until acknowledged.
- The arbiter grants one master with round-robin priority, drives a multi-cycle strobe to the slave until pready is seen or a timeout fires, then returns a one-cycle ack with read data or error.
- Sits between the cpu peripheral port and the memory-mapped peripherals (console 0xc0000000, sim-end 0xc0000004).

---
 rtl/periph_bus_pkg.sv | 21 ++
 rtl/periph_bus_arbiter_rr_arb2.sv | 23 ++
 rtl/periph_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
package periph_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [2:0]  SIZE_B = 3'd1;
   localparam logic [2:0]  SIZE_H = 3'd2;
   localparam logic [2:0]  SIZE_W = 3'd4;

   localparam logic [31:0] ADDR_CONSOLE = 32'hc000_0000;
   localparam logic [31:0] ADDR_SIMEND  = 32'hc000_0004;

   function automatic logic req_of(input logic rreq, input logic wreq);
      return rreq | wreq;
   endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr_arb2.sv
// Two-requester round-robin pick: on a tie the master that was not granted last wins.
module rr_arb2
   import periph_bus_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       grant_o,
   output logic       valid_o
);

   always_comb begin
      grant_o = 1'b0;
      case (req_i)
         2'b01:   grant_o = 1'b0;
         2'b10:   grant_o = 1'b1;
         2'b11:   grant_o = ~last_grant_i;
         default: grant_o = 1'b0;
      endcase
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral strobe bus between the CPU (m0) and a debug/DMA master (m1).
module periph_bus_arbiter
   import periph_bus_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [2:0]  m0_size,
   input  logic        m0_rreq,
   input  logic        m0_wreq,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [2:0]  m1_size,
   input  logic        m1_rreq,
   input  logic        m1_wreq,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic [31:0] paddr,
   output logic [31:0] pwrite,
   output logic [2:0]  psize,
   output logic        pread_req,
   output logic        pwrite_req,
   input  logic [31:0] pread,
   input  logic        pready,
   output logic        owner
);

   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              owner_q, last_grant_q;
   logic [31:0]       paddr_q, pwdata_q;
   logic [2:0]        psize_q;
   logic              prd_q, pwr_q;
   logic              m0_ack_q, m0_err_q, m1_ack_q, m1_err_q;
   logic [31:0]       m0_rdata_q, m1_rdata_q;

   logic [1:0]        req_s;
   logic              grant_s, valid_s, timeout_s;
   logic [31:0]       resp_data_s;

   assign req_s = {req_of(m1_rreq, m1_wreq), req_of(m0_rreq, m0_wreq)};

   rr_arb2 u_rr_arb2 (
      .req_i        (req_s),
      .last_grant_i (last_grant_q),
      .grant_o      (grant_s),
      .valid_o      (valid_s)
   );

   assign timeout_s   = (TIMEOUT != 0) && (cnt_q == TO_LAST);
   // A timed-out access or a write returns zero data.
   assign resp_data_s = (pready && prd_q) ? pread : 32'h0000_0000;

   // Arbitration FSM with all bus and response outputs registered.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         paddr_q      <= 32'h0000_0000;
         pwdata_q     <= 32'h0000_0000;
         psize_q      <= 3'd0;
         prd_q        <= 1'b0;
         pwr_q        <= 1'b0;
         m0_ack_q     <= 1'b0;
         m0_err_q     <= 1'b0;
         m0_rdata_q   <= 32'h0000_0000;
         m1_ack_q     <= 1'b0;
         m1_err_q     <= 1'b0;
         m1_rdata_q   <= 32'h0000_0000;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (valid_s) begin
                  owner_q  <= grant_s;
                  cnt_q    <= {CNT_W{1'b0}};
                  paddr_q  <= grant_s ? m1_addr  : m0_addr;
                  pwdata_q <= grant_s ? m1_wdata : m0_wdata;
                  psize_q  <= grant_s ? m1_size  : m0_size;
                  pwr_q    <= grant_s ? m1_wreq  : m0_wreq;
                  prd_q    <= grant_s ? ~m1_wreq : ~m0_wreq;
                  state_q  <= ST_BUSY;
               end else begin
                  state_q  <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (pready || timeout_s) begin
                  paddr_q    <= 32'h0000_0000;
                  pwdata_q   <= 32'h0000_0000;
                  psize_q    <= 3'd0;
                  prd_q      <= 1'b0;
                  pwr_q      <= 1'b0;
                  m0_ack_q   <= ~owner_q;
                  m0_err_q   <= ~owner_q & ~pready;
                  m0_rdata_q <= owner_q ? 32'h0000_0000 : resp_data_s;
                  m1_ack_q   <= owner_q;
                  m1_err_q   <= owner_q & ~pready;
                  m1_rdata_q <= owner_q ? resp_data_s : 32'h0000_0000;
                  state_q    <= ST_RESP;
               end else begin
                  cnt_q      <= cnt_q + CNT_W'(1);
               end
            end
            ST_RESP: begin
               m0_ack_q     <= 1'b0;
               m0_err_q     <= 1'b0;
               m0_rdata_q   <= 32'h0000_0000;
               m1_ack_q     <= 1'b0;
               m1_err_q     <= 1'b0;
               m1_rdata_q   <= 32'h0000_0000;
               last_grant_q <= owner_q;
               state_q      <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign paddr      = paddr_q;
   assign pwrite     = pwdata_q;
   assign psize      = psize_q;
   assign pread_req  = prd_q;
   assign pwrite_req = pwr_q;
   assign owner      = owner_q;
   assign m0_ack     = m0_ack_q;
   assign m0_err     = m0_err_q;
   assign m0_rdata   = m0_rdata_q;
   assign m1_ack     = m1_ack_q;
   assign m1_err     = m1_err_q;
   assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: vector table of single accesses plus hand-written tie, timeout and reset sequences.
module tb_periph_bus_arbiter;
   import periph_bus_pkg::*;

   localparam int TO = 16;

   logic        clock, reset_n;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata;
   logic [2:0]  m0_size, m1_size, psize;
   logic        m0_rreq, m0_wreq, m1_rreq, m1_wreq;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] paddr, pwrite, pread;
   logic        pread_req, pwrite_req, pready, owner;

   typedef struct {
      logic        m;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  size;
      int          waits;
      logic        stuck;
      logic        drop;
      logic [31:0] sdata;
      int          exp_stb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic        m;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[7];
   int   total = 0;
   int   bad   = 0;

   periph_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
      .m0_rreq(m0_rreq), .m0_wreq(m0_wreq),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
      .m1_rreq(m1_rreq), .m1_wreq(m1_wreq),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .paddr(paddr), .pwrite(pwrite), .psize(psize),
      .pread_req(pread_req), .pwrite_req(pwrite_req),
      .pread(pread), .pready(pready), .owner(owner)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic m, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
      if (m) begin
         m1_addr = a; m1_wdata = d; m1_size = s; m1_rreq = rd; m1_wreq = wr;
      end else begin
         m0_addr = a; m0_wdata = d; m0_size = s; m0_rreq = rd; m0_wreq = wr;
      end
   endtask

   task automatic clear_req(input logic m);
      if (m) begin
         m1_rreq = 1'b0; m1_wreq = 1'b0;
      end else begin
         m0_rreq = 1'b0; m0_wreq = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      clear_req(1'b0);
      clear_req(1'b1);
      pready = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Scoreboard: every ack is matched against the oldest expected completion.
   always @(negedge clock) begin
      if (reset_n && (m0_ack || m1_ack)) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got m0_ack=%b m1_ack=%b want none", m0_ack, m1_ack);
         end else begin
            mon_e = sb_q.pop_front();
            chk("ack_master", {31'b0, m1_ack}, {31'b0, mon_e.m});
            chk("ack_rdata", mon_e.m ? m1_rdata : m0_rdata, mon_e.rdata);
            chk("ack_err", {31'b0, mon_e.m ? m1_err : m0_err}, {31'b0, mon_e.err});
            chk("other_quiet",
                {31'b0, mon_e.m ? |{m0_ack, m0_err, m0_rdata} : |{m1_ack, m1_err, m1_rdata}},
                32'h0);
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int   stb, first_n, ack_n;
      logic bus_ok, own;
      stb = 0; first_n = 0; ack_n = 0; bus_ok = 1'b1; own = 1'b0;
      @(negedge clock);
      drive_req(v.m, v.rd, v.wr, v.addr, v.wdata, v.size);
      pready = 1'b0;
      pread  = v.sdata;
      sb_q.push_back('{v.m, v.exp_rdata, v.exp_err});
      for (int n = 1; n <= 60 && ack_n == 0; n++) begin
         @(negedge clock);
         if (pread_req || pwrite_req) begin
            stb++;
            if (first_n == 0) first_n = n;
            if (paddr !== v.addr || pwrite !== v.wdata || psize !== v.size ||
                pwrite_req !== v.wr || pread_req !== !v.wr)
               bus_ok = 1'b0;
            if (v.drop && stb == 1) clear_req(v.m);
         end
         pready = !v.stuck && (stb > v.waits);
         if (v.m ? m1_ack : m0_ack) begin
            ack_n = n;
            own   = owner;
            clear_req(v.m);
            pready = 1'b0;
         end
      end
      if (ack_n == 0) begin
         chk("ack_seen", 32'h0, 32'h1);
         clear_req(v.m);
      end
      chk("strobe_cycles", 32'(stb), 32'(v.exp_stb));
      chk("strobe_latency", 32'(first_n), 32'h1);
      chk("ack_latency", 32'(ack_n), 32'(v.exp_stb + 1));
      chk("bus_fields", {31'b0, bus_ok}, 32'h1);
      chk("owner", {31'b0, own}, {31'b0, v.m});
   endtask

   initial begin
      int   acks;
      logic pos_ok, seen, first_m;
      reset_n = 1'b0;
      m0_addr = 32'h0; m0_wdata = 32'h0; m0_size = 3'd0; m0_rreq = 1'b0; m0_wreq = 1'b0;
      m1_addr = 32'h0; m1_wdata = 32'h0; m1_size = 3'd0; m1_rreq = 1'b0; m1_wreq = 1'b0;
      pread = 32'h0; pready = 1'b0;

      vecs[0] = '{1'b0, 1'b0, 1'b1, ADDR_CONSOLE,  32'h0000_002a, SIZE_W, 0, 1'b0, 1'b0, 32'h0000_0000, 1,  32'h0000_0000, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 32'hc000_0010, 32'h0000_0000, SIZE_W, 3, 1'b0, 1'b0, 32'hdead_beef, 4,  32'hdead_beef, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, ADDR_SIMEND,   32'h0000_0000, SIZE_H, 1, 1'b0, 1'b0, 32'h0000_a5a5, 2,  32'h0000_a5a5, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, ADDR_CONSOLE,  32'h0000_00ff, SIZE_B, 0, 1'b0, 1'b0, 32'h7777_7777, 1,  32'h0000_0000, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 32'hc000_0020, 32'h0000_0000, SIZE_W, 0, 1'b1, 1'b0, 32'h5555_5555, TO, 32'h0000_0000, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 32'hc000_0030, 32'h0000_0000, SIZE_W, 0, 1'b0, 1'b0, 32'h1234_5678, 1,  32'h1234_5678, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 1'b1, ADDR_SIMEND,   32'h0000_0001, SIZE_W, 2, 1'b0, 1'b1, 32'h0000_0000, 3,  32'h0000_0000, 1'b0};

      repeat (3) @(negedge clock);
      chk("rst_strobes", {30'b0, pread_req, pwrite_req}, 32'h0);
      chk("rst_bus", paddr | pwrite | {29'b0, psize}, 32'h0);
      chk("rst_acks", {28'b0, m0_ack, m0_err, m1_ack, m1_err}, 32'h0);
      chk("rst_rdata_owner", m0_rdata | m1_rdata | {31'b0, owner}, 32'h0);
      reset_n = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Both masters hold requests: grants must alternate starting with m0, one ack every 3 cycles.
      do_reset();
      @(negedge clock);
      drive_req(1'b0, 1'b0, 1'b1, ADDR_CONSOLE, 32'h0000_0011, SIZE_W);
      drive_req(1'b1, 1'b0, 1'b1, ADDR_CONSOLE, 32'h0000_0022, SIZE_W);
      pready = 1'b1;
      for (int k = 0; k < 8; k++) sb_q.push_back('{k[0], 32'h0, 1'b0});
      acks = 0; pos_ok = 1'b1;
      for (int n = 1; n <= 40 && acks < 8; n++) begin
         @(negedge clock);
         if (m0_ack || m1_ack) begin
            acks++;
            if ((n % 3) != 2) pos_ok = 1'b0;
            if (acks == 8) begin
               clear_req(1'b0);
               clear_req(1'b1);
            end
         end
      end
      clear_req(1'b0);
      clear_req(1'b1);
      pready = 1'b0;
      chk("rr_ack_count", 32'(acks), 32'd8);
      chk("rr_ack_spacing", {31'b0, pos_ok}, 32'h1);

      // Reset in the middle of an access: strobe and acks drop at once, nothing is acked.
      @(negedge clock);
      drive_req(1'b1, 1'b1, 1'b0, 32'hc000_0010, 32'h0, SIZE_W);
      pready = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clock);
         if (pread_req) seen = 1'b1;
      end
      chk("busy_before_reset", {31'b0, seen}, 32'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_strobes", {30'b0, pread_req, pwrite_req}, 32'h0);
      chk("async_rst_acks_owner", {29'b0, m0_ack, m1_ack, owner}, 32'h0);
      clear_req(1'b1);
      @(negedge clock);
      reset_n = 1'b1;

      @(negedge clock);
      drive_req(1'b0, 1'b1, 1'b0, 32'hc000_0040, 32'h0, SIZE_W);
      drive_req(1'b1, 1'b1, 1'b0, 32'hc000_0044, 32'h0, SIZE_W);
      pread = 32'h0bad_f00d;
      pready = 1'b1;
      sb_q.push_back('{1'b0, 32'h0bad_f00d, 1'b0});
      sb_q.push_back('{1'b1, 32'h0bad_f00d, 1'b0});
      acks = 0; first_m = 1'b1;
      for (int n = 0; n < 20 && acks < 2; n++) begin
         @(negedge clock);
         if (m0_ack) begin
            if (acks == 0) first_m = 1'b0;
            acks++;
            clear_req(1'b0);
         end
         if (m1_ack) begin
            acks++;
            clear_req(1'b1);
         end
      end
      clear_req(1'b0);
      clear_req(1'b1);
      pready = 1'b0;
      chk("post_reset_tie_m0", {31'b0, first_m}, 32'h0);
      chk("post_reset_acks", 32'(acks), 32'd2);

      repeat (3) @(negedge clock);
      chk("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
